// File: rtl/gpt_pkg.sv
// Shared timer definitions: input-capture prescaler encoding and default counter width.
package gpt_pkg;

  localparam int GPT_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IC_DIV1 = 2'd0,
    IC_DIV2 = 2'd1,
    IC_DIV4 = 2'd2,
    IC_DIV8 = 2'd3
  } ic_psc_e;

  // Prescaler count value at which the next active edge completes a capture.
  function automatic logic [2:0] psc_last(input ic_psc_e psc);
    case (psc)
      IC_DIV1: return 3'd0;
      IC_DIV2: return 3'd1;
      IC_DIV4: return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/ic_filter.sv
// Digital glitch filter: q follows d only after d has differed from it for len
// consecutive clocks; len = 0 passes d straight through.
module ic_filter (
  input  logic       clk_i,
  input  logic       areset_i,
  input  logic       d,
  input  logic [3:0] len,
  output logic       q
);

  logic       q_r;
  logic [3:0] cnt_r;

  // In bypass the register shadows d so a later non-zero len starts clean.
  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      q_r   <= 1'b0;
      cnt_r <= 4'd0;
    end else if (len == 4'd0) begin
      q_r   <= d;
      cnt_r <= 4'd0;
    end else if (d == q_r) begin
      cnt_r <= 4'd0;
    end else if (cnt_r >= len - 4'd1) begin
      q_r   <= d;
      cnt_r <= 4'd0;
    end else begin
      cnt_r <= cnt_r + 4'd1;
    end
  end

  assign q = (len == 4'd0) ? d : q_r;

endmodule

// File: rtl/input_capture.sv
// Timer input-capture channel: sync2, optional digital filter (INPUT_CAPTURE_FILTER_EN),
// edge select, edge prescaler, capture register with sticky capture/overcapture flags.
module input_capture
  import gpt_pkg::*;
#(
  parameter int CNT_WIDTH = GPT_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 areset_i,
  input  logic                 ic_i,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic                 enable_i,
  input  logic                 polarity_i,
  input  logic [1:0]           icpsc_i,
  input  logic [3:0]           icf_i,
  input  logic                 ccif_clr_i,
  input  logic                 ccof_clr_i,
  output logic [CNT_WIDTH-1:0] ccr_o,
  output logic                 capture_o,
  output logic                 ccif_o,
  output logic                 ccof_o
);

  logic [1:0] sync_q;
  logic       filt;
  logic       filt_d;
  logic [2:0] psc_cnt;
  logic [2:0] psc_base;
  logic [2:0] psc_next;
  logic [1:0] icpsc_q;
  logic       active_edge;
  logic       cap;

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], ic_i};
  end

`ifdef INPUT_CAPTURE_FILTER_EN
  ic_filter u_filter (
    .clk_i    (clk_i),
    .areset_i (areset_i),
    .d        (sync_q[1]),
    .len      (icf_i),
    .q        (filt)
  );
`else
  logic unused_icf;
  assign unused_icf = ^icf_i;
  assign filt       = sync_q[1];
`endif

  // Edge history and the prescaler-change detector run even while disabled,
  // so enabling never sees a stale level as a fresh edge.
  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      filt_d  <= 1'b0;
      icpsc_q <= 2'd0;
      psc_cnt <= 3'd0;
    end else begin
      filt_d  <= filt;
      icpsc_q <= icpsc_i;
      psc_cnt <= psc_next;
    end
  end

  always_comb begin
    active_edge = polarity_i ? (filt_d & ~filt) : (filt & ~filt_d);
    psc_base    = (icpsc_i != icpsc_q) ? 3'd0 : psc_cnt;
    psc_next    = psc_base;
    cap         = 1'b0;
    if (!enable_i) begin
      psc_next = 3'd0;
    end else if (active_edge) begin
      if (psc_base == psc_last(ic_psc_e'(icpsc_i))) begin
        cap      = 1'b1;
        psc_next = 3'd0;
      end else begin
        psc_next = psc_base + 3'd1;
      end
    end
  end

  // capture_o is a single-cycle strobe with no back-pressure: in the cycle it
  // is high, ccr_o already holds the newly captured count and ccif_o is set.
  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      ccr_o     <= '0;
      capture_o <= 1'b0;
      ccif_o    <= 1'b0;
      ccof_o    <= 1'b0;
    end else begin
      capture_o <= cap;
      if (cap) ccr_o <= cnt_i;
      if (cap)             ccif_o <= 1'b1;
      else if (ccif_clr_i) ccif_o <= 1'b0;
      if (cap && ccif_o)   ccof_o <= 1'b1;
      else if (ccof_clr_i) ccof_o <= 1'b0;
    end
  end

endmodule
